// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg
//   Values shared by the fetch PC generator, decode and CSR logic:
//   the default PC width, the reset and trap vector defaults, and the
//   encoding of the PC generator's BOOT/RUN/HALT state machine.
package pc_gen_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;

  // State encoding is kept as plain constants so older blocks that
  // compare against raw 2-bit codes keep working.
  typedef logic [1:0] state_t;
  localparam state_t ST_BOOT = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HALT = 2'd2;

endpackage

// File: rtl/pc_gen_align_chk.sv
// pc_align_chk
//   Combinational alignment checker, shared with the branch unit.
//   Flags a target whose low ALIGN_LSB bits are not all zero.
// Ports
//   target      in   XLEN  candidate PC
//   misaligned  out  1     1 when target[ALIGN_LSB-1:0] != 0
module pc_align_chk #(
  parameter int XLEN      = 32,
  parameter int ALIGN_LSB = 2
) (
  input  logic [XLEN-1:0] target,
  output logic            misaligned
);

  // Masking rather than slicing keeps ALIGN_LSB = 0 legal (never misaligned).
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_LSB) - XLEN'(1);

  assign misaligned = |(target & ALIGN_MASK);

endmodule

// File: rtl/pc_gen.sv
// pc_gen
//   Program-counter generator for the fetch stage. Produces the fetch
//   address with a valid/ready handshake, applies redirects and traps
//   with fixed priority, detects misaligned redirect targets and
//   supports a halt/resume state.
// Ports
//   clk_pc           in   1     clock, rising edge
//   rst_pc_n         in   1     synchronous active-low reset
//   fetch_ready      in   1     imem accepts the current pc
//   redirect_valid   in   1     branch/jump taken this cycle
//   redirect_target  in   XLEN  redirect destination
//   trap_valid       in   1     exception/interrupt request
//   halt_req         in   1     request to enter HALT
//   resume           in   1     leave HALT, restart at epc
//   pc               out  XLEN  current fetch address (registered)
//   pc_seq           out  XLEN  pc + STRIDE, wrapping
//   fetch_valid      out  1     pc is a live fetch request
//   misalign_err     out  1     one-cycle pulse on a misaligned redirect
//   epc              out  XLEN  captured pc/target (registered)
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEF),
  parameter int              STRIDE    = 4,
  parameter int              ALIGN_LSB = 2
) (
  input  logic            clk_pc,
  input  logic            rst_pc_n,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_seq,
  output logic            fetch_valid,
  output logic            misalign_err,
  output logic [XLEN-1:0] epc
);

  localparam logic [XLEN-1:0] STRIDE_X = XLEN'(STRIDE);

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] epc_reg;
  logic            misalign_reg;
  logic            target_misaligned;

  pc_align_chk #(
    .XLEN      (XLEN),
    .ALIGN_LSB (ALIGN_LSB)
  ) u_align_chk (
    .target     (redirect_target),
    .misaligned (target_misaligned)
  );

  // Natural XLEN-bit addition gives the modulo-2^XLEN wrap.
  assign pc_seq       = pc_reg + STRIDE_X;
  assign pc           = pc_reg;
  assign epc          = epc_reg;
  assign misalign_err = misalign_reg;
  assign fetch_valid  = (state_reg == ST_RUN);

  always_ff @(posedge clk_pc) begin
    if (!rst_pc_n) begin
      state_reg    <= ST_BOOT;
      pc_reg       <= RESET_VEC;
      epc_reg      <= '0;
      misalign_reg <= 1'b0;
    end else begin
      // Pulse output: cleared every cycle unless re-triggered below.
      misalign_reg <= 1'b0;
      case (state_reg)
        ST_BOOT: begin
          state_reg <= ST_RUN;
        end
        ST_RUN: begin
          // Trap and redirect flush the in-flight request, so they do
          // not wait for fetch_ready.
          if (trap_valid) begin
            pc_reg  <= TRAP_VEC;
            epc_reg <= pc_reg;
          end else if (redirect_valid && target_misaligned) begin
            pc_reg       <= TRAP_VEC;
            epc_reg      <= redirect_target;
            misalign_reg <= 1'b1;
          end else if (redirect_valid) begin
            pc_reg <= redirect_target;
          end else if (halt_req) begin
            state_reg <= ST_HALT;
            epc_reg   <= pc_reg;
          end else if (fetch_ready) begin
            pc_reg <= pc_seq;
          end
        end
        ST_HALT: begin
          if (trap_valid) begin
            state_reg <= ST_RUN;
            pc_reg    <= TRAP_VEC;
            epc_reg   <= pc_reg;
          end else if (resume) begin
            state_reg <= ST_RUN;
            pc_reg    <= epc_reg;
          end
        end
        default: begin
          state_reg <= ST_BOOT;
          pc_reg    <= RESET_VEC;
        end
      endcase
    end
  end

endmodule
